neuron_lut_loader: RTL

Runtime-programmable 8-input / 2-output neuron truth table for the sparse classification layers. It replaces a fixed per-neuron case ROM with distributed RAM. A streaming load port writes all 256 table entries, and a registered inference port then reads them back at one lookup per cycle. It sits between the host-side weight loader and the layer datapath, so table contents can change without re-synthesis.

---
 rtl/lut_pkg.sv | 17 +
 rtl/lut_dpram.sv | 42 ++++
 rtl/neuron_lut_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lut_pkg.sv
// Shared constants and state encoding for the runtime-loadable neuron truth table.
package lut_pkg;

   localparam int IN_BITS          = 8;
   localparam int OUT_BITS         = 2;
   localparam int LD_BITS          = 8;
   localparam int ENTRIES          = 2 ** IN_BITS;
   localparam int ENTRIES_PER_BEAT = LD_BITS / OUT_BITS;
   localparam int BEATS            = ENTRIES / ENTRIES_PER_BEAT;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      ARMED   = 2'd2
   } lut_state_t;

endpackage

// File: rtl/lut_dpram.sv
// Distributed truth-table RAM: one beat-wide synchronous write port and one
// entry-wide asynchronous read port. Contents are intentionally not reset.
module lut_dpram #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 2,
   parameter int LD_BITS  = 8,
   parameter int BEAT_W   = 6
) (
   input  logic                clk,
   input  logic                we,
   input  logic [BEAT_W-1:0]   waddr,
   input  logic [LD_BITS-1:0]  wdata,
   input  logic [IN_BITS-1:0]  raddr,
   output logic [OUT_BITS-1:0] rdata
);

   localparam int EPB   = LD_BITS / OUT_BITS;
   localparam int BEATS = 2 ** BEAT_W;
   localparam int SEL_W = $clog2(EPB);

   // One word per load beat, so a beat lands in a single write.
   (* ram_style = "distributed" *) logic [LD_BITS-1:0] mem [BEATS];

   logic [LD_BITS-1:0] word;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      word  = mem[raddr[IN_BITS-1:SEL_W]];
      rdata = '0;
      for (int j = 0; j < EPB; j++) begin
         if (raddr[SEL_W-1:0] == SEL_W'(j)) begin
            rdata = word[j*OUT_BITS +: OUT_BITS];
         end
      end
   end

endmodule

// File: rtl/neuron_lut_loader.sv
// Runtime-programmable neuron truth table: streaming beat loader followed by a
// registered one-lookup-per-cycle inference port.
module neuron_lut_loader
   import lut_pkg::*;
#(
   parameter int IN_BITS  = lut_pkg::IN_BITS,
   parameter int OUT_BITS = lut_pkg::OUT_BITS,
   parameter int LD_BITS  = lut_pkg::LD_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ld_start,
   input  logic                ld_valid,
   input  logic [LD_BITS-1:0]  ld_data,
   output logic                ld_ready,
   output logic                ld_done,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                in_ready,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] out_data,
   output logic                programmed,
   output lut_state_t          dbg_state
);

   localparam int EPB    = LD_BITS / OUT_BITS;
   localparam int NBEATS = (2 ** IN_BITS) / EPB;
   localparam int BEAT_W = $clog2(NBEATS);

   // Handshake: a load beat transfers on a rising edge where ld_valid && ld_ready;
   // a lookup transfers where in_valid && in_ready. Both readies are registered.
   lut_state_t          state_q, state_d;
   logic [BEAT_W-1:0]   cnt_q, cnt_d;
   logic                ld_ready_q, in_ready_q, programmed_q, ld_done_q;
   logic                done_d;
   logic                out_valid_q;
   logic [OUT_BITS-1:0] out_data_q;
   logic                we;
   logic                beat_acc;
   logic                look_acc;
   logic [OUT_BITS-1:0] rdata;

   assign beat_acc = ld_valid && ld_ready_q;
   assign look_acc = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we      = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         EMPTY: begin
            if (ld_start) begin
               state_d = LOADING;
               cnt_d   = '0;
            end
         end
         LOADING: begin
            // A restart outranks a beat presented in the same cycle.
            if (ld_start) begin
               cnt_d = '0;
            end else if (beat_acc) begin
               we    = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BEAT_W'(NBEATS - 1)) begin
                  state_d = ARMED;
                  done_d  = 1'b1;
               end
            end
         end
         ARMED: begin
            if (ld_start) begin
               state_d = LOADING;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = EMPTY;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         cnt_q        <= '0;
         ld_ready_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         programmed_q <= 1'b0;
         ld_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ld_ready_q   <= (state_d == LOADING);
         in_ready_q   <= (state_d == ARMED);
         programmed_q <= (state_d == ARMED);
         ld_done_q    <= done_d;
      end
   end

   // Result register; out_data keeps its last value between lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= look_acc;
         if (look_acc) begin
            out_data_q <= rdata;
         end
      end
   end

   lut_dpram #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS),
      .LD_BITS  (LD_BITS),
      .BEAT_W   (BEAT_W)
   ) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (cnt_q),
      .wdata (ld_data),
      .raddr (in_data),
      .rdata (rdata)
   );

   assign ld_ready   = ld_ready_q;
   assign in_ready   = in_ready_q;
   assign programmed = programmed_q;
   assign ld_done    = ld_done_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign dbg_state  = state_q;

endmodule
